// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared types and bus constants for the UART TX arbiter
package uart_tx_arb_pkg;
  typedef enum logic [1:0] {IDLE, PREFIX, GRANT, WRITE} state_t;
  localparam logic [31:0] UART_TX_DATA_ADDR = 32'h0;
  localparam logic [3:0] UART_TX_BE = 4'b0001;
endpackage

// File: rtl/naive_bus.sv
// naive_bus: simple request/grant memory-mapped bus
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, input rd_gnt, rd_data, wr_gnt);
  modport slave (input rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, output rd_gnt, rd_data, wr_gnt);
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after start
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic                 hit,
  output logic [$clog2(N)-1:0] idx
);
  localparam int W = $clog2(N);
  logic [W-1:0] j;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(start) + i) % N);
      if (req[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-locked round-robin sharing of the UART TX FIFO; UART_TX_ARB_PREFIX_EN adds a per-lock tag byte
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDLE_TIMEOUT = 64,
  parameter logic [7:0] PREFIX_BASE = 8'h41
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*8-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  naive_bus.master                   bus
);
  localparam int W = $clog2(N_REQ);
  localparam int TW = $clog2(IDLE_TIMEOUT) + 1;
`ifdef UART_TX_ARB_PREFIX_EN
  localparam state_t FIRST = PREFIX;
`else
  localparam state_t FIRST = GRANT;
`endif
  state_t state, state_d;
  logic [W-1:0] rr_ptr, rr_d, gid_d, pick_idx;
  logic pick_hit, rel, last_q, last_d, wr;
  logic [7:0] byte_q, byte_d;
  logic [TW-1:0] to_cnt, cnt_d;
  rr_pick #(.N(N_REQ)) u_pick (
    .req(req_valid),
    .start(rr_ptr),
    .hit(pick_hit),
    .idx(pick_idx)
  );
  always_comb begin
    state_d = state;
    rr_d = rr_ptr;
    gid_d = grant_id;
    byte_d = byte_q;
    last_d = last_q;
    cnt_d = to_cnt;
    rel = 1'b0;
    case (state)
      IDLE: if (pick_hit) begin
        gid_d = pick_idx;
        state_d = FIRST;
      end
      PREFIX: begin
        byte_d = PREFIX_BASE + 8'(grant_id);
        last_d = 1'b0;
        state_d = WRITE;
      end
      GRANT: if (req_valid[grant_id]) begin
        byte_d = req_data[{grant_id, 3'b000} +: 8];
        last_d = req_last[grant_id];
        cnt_d = '0;
        state_d = WRITE;
      end else if (to_cnt == TW'(IDLE_TIMEOUT - 1)) rel = 1'b1;
      else cnt_d = to_cnt + 1'b1;
      WRITE: if (bus.wr_gnt) begin
        rel = last_q;
        state_d = GRANT;
      end
      default: state_d = IDLE;
    endcase
    if (rel) begin
      rr_d = (grant_id == W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      cnt_d = '0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      byte_q <= '0;
      last_q <= 1'b0;
      to_cnt <= '0;
    end else begin
      state <= state_d;
      rr_ptr <= rr_d;
      grant_id <= gid_d;
      byte_q <= byte_d;
      last_q <= last_d;
      to_cnt <= cnt_d;
    end
  assign wr = state == WRITE;
  assign busy = state != IDLE;
  assign req_ready = (state == GRANT) ? (N_REQ'(1) << grant_id) : '0;
  assign bus.wr_req = wr;
  assign bus.wr_addr = wr ? UART_TX_DATA_ADDR : '0;
  assign bus.wr_be = wr ? UART_TX_BE : '0;
  assign bus.wr_data = wr ? {24'h0, byte_q} : '0;
  assign bus.rd_req = 1'b0;
  assign bus.rd_addr = '0;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  typedef struct packed {
    logic [7:0]  d;
    logic [31:0] a;
    logic [3:0]  be;
    logic        id;
    int          cyc;
  } wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0] req_last = '0;
  logic [1:0] req_ready;
  logic grant_id;
  logic busy;
  logic gnt = 1'b1;
  logic [1:0] acc;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int rd0 = 0;
  int rd1 = 0;
  wr_t log_q[$];
  int cyc = 0;
  int ready_bad = 0;
  int checks = 0;
  int errors = 0;
  naive_bus bus_if ();
  assign bus_if.wr_gnt = gnt;
  assign bus_if.rd_gnt = 1'b0;
  assign bus_if.rd_data = '0;
  uart_tx_arbiter #(.N_REQ(2), .IDLE_TIMEOUT(16), .PREFIX_BASE(8'h41)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .grant_id(grant_id),
    .busy(busy),
    .bus(bus_if)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus_if.wr_req && bus_if.wr_gnt)
      log_q.push_back('{d: bus_if.wr_data[7:0], a: bus_if.wr_addr, be: bus_if.wr_be, id: grant_id, cyc: cyc});
  end
  always @(negedge clk)
    if ((req_ready & (req_ready - 2'd1)) != 2'd0) ready_bad = ready_bad + 1;
  function automatic void drive();
    req_valid[0] = rd0 < q0.size();
    req_data[7:0] = req_valid[0] ? q0[rd0][7:0] : 8'h0;
    req_last[0] = req_valid[0] && q0[rd0][8];
    req_valid[1] = rd1 < q1.size();
    req_data[15:8] = req_valid[1] ? q1[rd1][7:0] : 8'h0;
    req_last[1] = req_valid[1] && q1[rd1][8];
  endfunction
  initial forever begin
    @(posedge clk);
    acc = req_ready & req_valid;
    #1;
    if (acc[0]) rd0++;
    if (acc[1]) rd1++;
    drive();
    @(negedge clk);
    #1;
    drive();
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
  task automatic push(input int r, input logic [7:0] b, input logic l);
    if (r == 0) q0.push_back({l, b});
    else q1.push_back({l, b});
  endtask
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic wait_log(input int n, input int lim);
    int t = 0;
    while (log_q.size() < n && t < lim) begin
      @(negedge clk);
      t++;
    end
  endtask
  task automatic test_reset();
    int nb = 0, nw = 0, nr = 0, nd = 0, ng = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus_if.wr_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_asserted: busy %b wr_req %b, expected 0 0", busy, bus_if.wr_req);
    end
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0) nb++;
      if (bus_if.wr_req !== 1'b0) nw++;
      if (req_ready !== 2'b00) nr++;
      if (bus_if.wr_data !== 32'h0 || bus_if.wr_addr !== 32'h0 || bus_if.wr_be !== 4'h0) nd++;
      if (grant_id !== 1'b0 || bus_if.rd_req !== 1'b0 || bus_if.rd_addr !== 32'h0) ng++;
    end
    checks++;
    if (nb !== 0) begin errors++; $display("FAIL idle_busy: %0d cycles busy, expected 0", nb); end
    checks++;
    if (nw !== 0) begin errors++; $display("FAIL idle_wr_req: %0d cycles wr_req, expected 0", nw); end
    checks++;
    if (nr !== 0) begin errors++; $display("FAIL idle_ready: %0d cycles ready, expected 0", nr); end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL idle_bus: %0d cycles nonzero wr bus, expected 0", nd); end
    checks++;
    if (ng !== 0) begin errors++; $display("FAIL idle_gid_rd: %0d cycles nonzero grant_id/rd, expected 0", ng); end
  endtask
  task automatic test_hi();
    logic [7:0] exp_d [3] = '{8'h48, 8'h69, 8'h0A};
    int lb, k;
    apply_reset();
    lb = log_q.size();
    @(negedge clk);
    k = cyc;
    push(0, 8'h48, 1'b0);
    push(0, 8'h69, 1'b0);
    push(0, 8'h0A, 1'b1);
    wait_log(lb + 3, 60);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL hi_busy_fall: busy %b, expected 0", busy); end
    checks++;
    if (log_q.size() !== lb + 3) begin errors++; $display("FAIL hi_count: %0d writes, expected 3", log_q.size() - lb); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_q[lb+i].d !== exp_d[i] || log_q[lb+i].a !== 32'h0 || log_q[lb+i].be !== 4'b0001 || log_q[lb+i].id !== 1'b0)
        begin errors++; $display("FAIL hi_byte%0d: data %h addr %h be %b id %b, expected %h 0 0001 0", i, log_q[lb+i].d, log_q[lb+i].a, log_q[lb+i].be, log_q[lb+i].id, exp_d[i]); end
    end
    checks++;
    if (log_q[lb].cyc - k !== 3) begin errors++; $display("FAIL hi_latency: %0d cycles, expected 3", log_q[lb].cyc - k); end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (log_q[lb+i].cyc - log_q[lb+i-1].cyc !== 2)
        begin errors++; $display("FAIL hi_spacing%0d: %0d cycles, expected 2", i, log_q[lb+i].cyc - log_q[lb+i-1].cyc); end
    end
  endtask
  task automatic test_pair();
    logic [7:0] exp_d [12] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    logic exp_id [12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    int lb;
    apply_reset();
    lb = log_q.size();
    @(negedge clk);
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 3; i++) begin
        push(0, exp_d[m*6+i], i == 2);
        push(1, exp_d[m*6+3+i], i == 2);
      end
    wait_log(lb + 12, 200);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (log_q[lb+i].d !== exp_d[i] || log_q[lb+i].id !== exp_id[i])
        begin errors++; $display("FAIL pair_byte%0d: data %h id %b, expected %h %b", i, log_q[lb+i].d, log_q[lb+i].id, exp_d[i], exp_id[i]); end
    end
    checks++;
    if (ready_bad !== 0) begin errors++; $display("FAIL ready_onehot: %0d bad cycles, expected 0", ready_bad); end
  endtask
  task automatic test_stall();
    int lb, t = 0, nbad = 0;
    apply_reset();
    lb = log_q.size();
    gnt = 1'b0;
    push(0, 8'h55, 1'b1);
    while (bus_if.wr_req !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bus_if.wr_req !== 1'b1) begin errors++; $display("FAIL stall_reach_write: wr_req %b, expected 1", bus_if.wr_req); end
    repeat (50) begin
      @(negedge clk);
      if (bus_if.wr_req !== 1'b1 || bus_if.wr_data !== 32'h55 || bus_if.wr_be !== 4'b0001 || busy !== 1'b1) nbad++;
    end
    checks++;
    if (nbad !== 0) begin errors++; $display("FAIL stall_stable: %0d unstable cycles, expected 0", nbad); end
    checks++;
    if (log_q.size() !== lb) begin errors++; $display("FAIL stall_no_write: %0d writes, expected 0", log_q.size() - lb); end
    gnt = 1'b1;
    wait_log(lb + 1, 10);
    repeat (5) @(negedge clk);
    checks++;
    if (log_q.size() !== lb + 1 || log_q[lb].d !== 8'h55)
      begin errors++; $display("FAIL stall_one_write: %0d writes data %h, expected 1 55", log_q.size() - lb, log_q[lb].d); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_release: busy %b, expected 0", busy); end
  endtask
  task automatic test_timeout();
    int lb, n = 0;
    apply_reset();
    lb = log_q.size();
    push(1, 8'h31, 1'b0);
    wait_log(lb + 1, 40);
    checks++;
    if (log_q[lb].d !== 8'h31 || log_q[lb].id !== 1'b1)
      begin errors++; $display("FAIL to_byte: data %h id %b, expected 31 1", log_q[lb].d, log_q[lb].id); end
    checks++;
    if (req_ready !== 2'b10 || grant_id !== 1'b1)
      begin errors++; $display("FAIL to_held: ready %b gid %b, expected 10 1", req_ready, grant_id); end
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL to_cycles: %0d grant cycles, expected 16", n); end
    push(0, 8'h30, 1'b1);
    wait_log(lb + 2, 40);
    checks++;
    if (log_q[lb+1].d !== 8'h30 || log_q[lb+1].id !== 1'b0)
      begin errors++; $display("FAIL to_next: data %h id %b, expected 30 0", log_q[lb+1].d, log_q[lb+1].id); end
  endtask
  task automatic test_prefix();
    int lb;
    apply_reset();
    lb = log_q.size();
    push(1, 8'h58, 1'b1);
    wait_log(lb + 2, 40);
    checks++;
    if (log_q[lb].d !== 8'h42 || log_q[lb].id !== 1'b1)
      begin errors++; $display("FAIL pfx_tag: data %h id %b, expected 42 1", log_q[lb].d, log_q[lb].id); end
    checks++;
    if (log_q[lb+1].d !== 8'h58 || log_q[lb+1].id !== 1'b1)
      begin errors++; $display("FAIL pfx_byte: data %h id %b, expected 58 1", log_q[lb+1].d, log_q[lb+1].id); end
  endtask
  initial begin
    test_reset();
`ifdef UART_TX_ARB_PREFIX_EN
    test_prefix();
`else
    test_hi();
    test_pair();
    test_stall();
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
